// File: rtl/poly_mau_pkg.sv
// Shared encodings and parameter-set constants for the polynomial modular arithmetic unit.
package poly_mau_pkg;

    localparam logic [3:0] MAU_ADD = 4'b0000;
    localparam logic [3:0] MAU_SUB = 4'b0001;
    localparam logic [3:0] MAU_CT  = 4'b0010;
    localparam logic [3:0] MAU_GS  = 4'b0011;
    localparam logic [3:0] MAU_PWM = 4'b0100;

    localparam logic [1:0] MAU_COMPRESS_NONE   = 2'b00;
    localparam logic [1:0] MAU_DECOMPOSE_NONE  = 2'b00;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_M = 5039;
    localparam int KYBER_N = 12;
    localparam int DIL_Q   = 8380417;
    localparam int DIL_M   = 8396807;
    localparam int DIL_N   = 23;

    // Control bits that travel alongside the data in every pipeline stage.
    typedef struct packed {
        logic       valid;
        logic [3:0] mode;
    } mau_ctl_t;

endpackage

// File: rtl/poly_mau_barrett.sv
// Two-stage Barrett reducer: stage 1 forms p - floor(p*m >> 2N)*q, stage 2 applies
// up to two conditional subtractions so the result lands in [0, q).
module poly_mau_barrett #(
    parameter int DW = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [2*DW-1:0] p,
    input  logic [DW-1:0]   q,
    input  logic [24:0]     m,
    input  logic [4:0]      n,
    output logic [DW-1:0]   r
);

    localparam int PW = 2 * DW;
    localparam int MW = 2 * DW + 25;

    logic [MW-1:0] pm;
    logic [MW-1:0] t_full;
    logic [PW-1:0] tq;
    logic [PW-1:0] r_raw;
    logic [DW+1:0] r1;
    logic [DW-1:0] q1;
    logic [DW+1:0] c1;
    logic [DW+1:0] c2;

    // Full-width p*m keeps the quotient estimate exact; only the shifted value is narrowed.
    assign pm     = {25'b0, p} * {{PW{1'b0}}, m};
    assign t_full = pm >> {n, 1'b0};
    assign tq     = t_full[PW-1:0] * {{DW{1'b0}}, q};
    assign r_raw  = p - tq;

    // The estimate undershoots by at most 2q, so r_raw < 3q fits in DW+2 bits.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r1 <= '0;
            q1 <= '0;
        end else begin
            r1 <= r_raw[DW+1:0];
            q1 <= q;
        end
    end

    assign c1 = (r1 >= {2'b00, q1}) ? r1 - {2'b00, q1} : r1;
    assign c2 = (c1 >= {2'b00, q1}) ? c1 - {2'b00, q1} : c1;

    always_ff @(posedge clk) begin
        if (rst_n) r <= '0;
        else       r <= c2[DW-1:0];
    end

    logic unused_bits;
    assign unused_bits = ^{t_full[MW-1:PW], r_raw[PW-1:DW+2], c2[DW+1:DW]};

endmodule

// File: rtl/poly_mau.sv
// Four-stage modular add/sub/multiply/butterfly unit sharing one multiplier and one Barrett reducer.
// Handshake: poly_enable qualifies the operands for one cycle; poly_valid follows it exactly 4 cycles later, no backpressure.
module poly_mau
    import poly_mau_pkg::*;
#(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          poly_kd_sel,
    input  logic          poly_pwm2_odd_even_sel,
    input  logic [1:0]    poly_duv_mode,
    input  logic [3:0]    poly_alu_mode,
    input  logic [1:0]    poly_compress,
    input  logic [1:0]    poly_decompose,
    input  logic [DW-1:0] poly_mau_a,
    input  logic [DW-1:0] poly_mau_b,
    input  logic [DW-1:0] poly_mau_c,
    input  logic [DW-1:0] poly_mau_d,
    input  logic [DW-1:0] poly_q,
    input  logic [24:0]   poly_barret_m,
    input  logic [4:0]    poly_mm_N,
    input  logic          poly_enable,
    output logic          poly_valid,
    output logic [DW-1:0] poly_mau_o0,
    output logic [DW-1:0] poly_mau_o1
);

    function automatic logic [DW-1:0] mod_add(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic [DW-1:0] qq);
        logic [DW:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, qq}) s = s - {1'b0, qq};
        return s[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] mod_sub(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                              input logic [DW-1:0] qq);
        return (x >= y) ? x - y : x + qq - y;
    endfunction

    logic [DW-1:0] op_mask;
    assign op_mask = poly_kd_sel ? {DW{1'b1}} : {{(DW-12){1'b0}}, 12'hfff};

    // S1: operand and parameter capture
    mau_ctl_t      ctl1;
    logic [DW-1:0] a1, b1, c1, d1, q1;
    logic [24:0]   m1;
    logic [4:0]    n1;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            ctl1 <= '0;
            a1 <= '0; b1 <= '0; c1 <= '0; d1 <= '0; q1 <= '0;
            m1 <= '0;
            n1 <= '0;
        end else begin
            ctl1 <= '{valid: poly_enable, mode: poly_alu_mode};
            a1 <= poly_mau_a & op_mask;
            b1 <= poly_mau_b & op_mask;
            c1 <= poly_mau_c & op_mask;
            d1 <= poly_mau_d & op_mask;
            q1 <= poly_q;
            m1 <= poly_barret_m;
            n1 <= poly_mm_N;
        end
    end

    // S2: pre-add/sub and the shared multiplier
    logic [DW-1:0]   mul_x, mul_y, r0_n, r1_n;
    logic [2*DW-1:0] p_n;

    always_comb begin
        mul_x = '0;
        mul_y = '0;
        r0_n  = '0;
        r1_n  = '0;
        case (ctl1.mode)
            MAU_ADD: begin
                r0_n = mod_add(a1, b1, q1);
                r1_n = mod_add(c1, d1, q1);
            end
            MAU_SUB: begin
                r0_n = mod_sub(a1, b1, q1);
                r1_n = mod_sub(c1, d1, q1);
            end
            MAU_CT: begin
                mul_x = b1;
                mul_y = c1;
            end
            MAU_GS: begin
                r0_n  = mod_add(a1, b1, q1);
                mul_x = mod_sub(a1, b1, q1);
                mul_y = c1;
            end
            MAU_PWM: begin
                mul_x = a1;
                mul_y = b1;
            end
            default: ;
        endcase
    end

    assign p_n = {{DW{1'b0}}, mul_x} * {{DW{1'b0}}, mul_y};

    mau_ctl_t        ctl2, ctl3, ctl4;
    logic [DW-1:0]   a2, a3, a4, q2, q3, q4;
    logic [DW-1:0]   r0_2, r0_3, r0_4, r1_2, r1_3, r1_4;
    logic [2*DW-1:0] p2;
    logic [24:0]     m2;
    logic [4:0]      n2;

    // S2..S4 registers: non-multiplied results ride alongside the two reducer stages
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ctl2 <= '0; ctl3 <= '0; ctl4 <= '0;
            a2 <= '0; a3 <= '0; a4 <= '0;
            q2 <= '0; q3 <= '0; q4 <= '0;
            r0_2 <= '0; r0_3 <= '0; r0_4 <= '0;
            r1_2 <= '0; r1_3 <= '0; r1_4 <= '0;
            p2 <= '0;
            m2 <= '0;
            n2 <= '0;
        end else begin
            ctl2 <= ctl1; ctl3 <= ctl2; ctl4 <= ctl3;
            a2 <= a1; a3 <= a2; a4 <= a3;
            q2 <= q1; q3 <= q2; q4 <= q3;
            r0_2 <= r0_n; r0_3 <= r0_2; r0_4 <= r0_3;
            r1_2 <= r1_n; r1_3 <= r1_2; r1_4 <= r1_3;
            p2 <= p_n;
            m2 <= m1;
            n2 <= n1;
        end
    end

    logic [DW-1:0] br;

    poly_mau_barrett #(.DW(DW)) u_barrett (
        .clk   (clk),
        .rst_n (rst_n),
        .p     (p2),
        .q     (q2),
        .m     (m2),
        .n     (n2),
        .r     (br)
    );

    // Output stage: butterfly add/sub against the reduced product, zero when idle
    logic [DW-1:0] o0_n, o1_n;

    always_comb begin
        o0_n = '0;
        o1_n = '0;
        if (ctl4.valid) begin
            case (ctl4.mode)
                MAU_ADD, MAU_SUB: begin
                    o0_n = r0_4;
                    o1_n = r1_4;
                end
                MAU_CT: begin
                    o0_n = mod_add(a4, br, q4);
                    o1_n = mod_sub(a4, br, q4);
                end
                MAU_GS: begin
                    o0_n = r0_4;
                    o1_n = br;
                end
                MAU_PWM: o0_n = br;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            poly_valid  <= 1'b0;
            poly_mau_o0 <= '0;
            poly_mau_o1 <= '0;
        end else begin
            poly_valid  <= ctl4.valid;
            poly_mau_o0 <= o0_n;
            poly_mau_o1 <= o1_n;
        end
    end

    logic unused_reserved;
    assign unused_reserved = ^{poly_pwm2_odd_even_sel, poly_duv_mode, poly_compress, poly_decompose};

endmodule

// File: tb/tb_poly_mau.sv
// Randomised scoreboard bench for poly_mau against a plain-arithmetic modular model.
module tb_poly_mau;
    import poly_mau_pkg::*;

    localparam int DW = 24;
    localparam int EW = 32 + 2 * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          poly_kd_sel = 1'b0;
    logic          poly_pwm2_odd_even_sel = 1'b0;
    logic [1:0]    poly_duv_mode = '0;
    logic [3:0]    poly_alu_mode = '0;
    logic [1:0]    poly_compress = '0;
    logic [1:0]    poly_decompose = '0;
    logic [DW-1:0] poly_mau_a = '0, poly_mau_b = '0, poly_mau_c = '0, poly_mau_d = '0;
    logic [DW-1:0] poly_q = '0;
    logic [24:0]   poly_barret_m = '0;
    logic [4:0]    poly_mm_N = '0;
    logic          poly_enable = 1'b0;
    logic          poly_valid;
    logic [DW-1:0] poly_mau_o0, poly_mau_o1;

    poly_mau #(.DW(DW)) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .poly_kd_sel            (poly_kd_sel),
        .poly_pwm2_odd_even_sel (poly_pwm2_odd_even_sel),
        .poly_duv_mode          (poly_duv_mode),
        .poly_alu_mode          (poly_alu_mode),
        .poly_compress          (poly_compress),
        .poly_decompose         (poly_decompose),
        .poly_mau_a             (poly_mau_a),
        .poly_mau_b             (poly_mau_b),
        .poly_mau_c             (poly_mau_c),
        .poly_mau_d             (poly_mau_d),
        .poly_q                 (poly_q),
        .poly_barret_m          (poly_barret_m),
        .poly_mm_N              (poly_mm_N),
        .poly_enable            (poly_enable),
        .poly_valid             (poly_valid),
        .poly_mau_o0            (poly_mau_o0),
        .poly_mau_o1            (poly_mau_o1)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [EW-1:0] exp_q[$];
    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Reference model: straight modular arithmetic on integers
    function automatic void model(input logic kd, input logic [3:0] mode,
                                  input longint a_in, input longint b_in,
                                  input longint c_in, input longint d_in,
                                  output longint e0, output longint e1);
        longint q, a, b, c, d, t;
        q = kd ? 64'd8380417 : 64'd3329;
        a = kd ? a_in : (a_in & 4095);
        b = kd ? b_in : (b_in & 4095);
        c = kd ? c_in : (c_in & 4095);
        d = kd ? d_in : (d_in & 4095);
        e0 = 0;
        e1 = 0;
        case (mode)
            4'd0: begin e0 = (a + b) % q; e1 = (c + d) % q; end
            4'd1: begin e0 = (a - b + q) % q; e1 = (c - d + q) % q; end
            4'd2: begin t = (b * c) % q; e0 = (a + t) % q; e1 = (a - t + q) % q; end
            4'd3: begin e0 = (a + b) % q; e1 = (((a - b + q) % q) * c) % q; end
            4'd4: begin e0 = (a * b) % q; e1 = 0; end
            default: ;
        endcase
    endfunction

    // Driver tasks
    task automatic drive(input logic kd, input logic [3:0] mode, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [DW-1:0] c, input logic [DW-1:0] d);
        poly_enable   = 1'b1;
        poly_kd_sel   = kd;
        poly_alu_mode = mode;
        poly_q        = kd ? DW'(DIL_Q) : DW'(KYBER_Q);
        poly_barret_m = kd ? 25'(DIL_M) : 25'(KYBER_M);
        poly_mm_N     = kd ? 5'(DIL_N) : 5'(KYBER_N);
        poly_mau_a = a; poly_mau_b = b; poly_mau_c = c; poly_mau_d = d;
        poly_pwm2_odd_even_sel = 1'($urandom_range(0, 1));
        poly_duv_mode = 2'($urandom_range(0, 3));
    endtask

    task automatic issue_exp(input logic kd, input logic [3:0] mode, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [DW-1:0] c, input logic [DW-1:0] d,
                             input logic [DW-1:0] e0, input logic [DW-1:0] e1);
        @(negedge clk);
        drive(kd, mode, a, b, c, d);
        exp_q.push_back({32'(cycle + 1), e0, e1});
    endtask

    task automatic issue_model(input logic kd, input logic [3:0] mode, input logic [DW-1:0] a,
                               input logic [DW-1:0] b, input logic [DW-1:0] c, input logic [DW-1:0] d);
        longint e0, e1;
        model(kd, mode, a, b, c, d, e0, e1);
        issue_exp(kd, mode, a, b, c, d, DW'(e0), DW'(e1));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            poly_enable = 1'b0;
            poly_alu_mode = 4'($urandom_range(0, 15));
            poly_mau_a = DW'($urandom); poly_mau_b = DW'($urandom);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (mon_en) begin
            if (poly_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("o0", 64'(poly_mau_o0), 64'(e[2*DW-1:DW]));
                    check("o1", 64'(poly_mau_o1), 64'(e[DW-1:0]));
                    check("latency", 64'(cycle), 64'(e[EW-1:2*DW] + 32'd4));
                end
            end else if (poly_valid === 1'b0) begin
                check("idle_o0", 64'(poly_mau_o0), 64'd0);
                check("idle_o1", 64'(poly_mau_o1), 64'd0);
            end else begin
                check("valid_known", 64'(poly_valid), 64'd0);
            end
        end
    end

    int pwm_a[6] = '{245, 1603, 497, 940, 2815, 2961};
    int pwm_e[6] = '{269, 904, 3304, 13, 2819, 1539};

    initial begin
        longint e0, e1;
        int k;
        logic kd;
        logic [3:0] mode;
        logic [DW-1:0] q, ra, rb, rc, rd;

        // Reset state
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(poly_valid), 64'd0);
        check("reset_o0", 64'(poly_mau_o0), 64'd0);
        check("reset_o1", 64'(poly_mau_o1), 64'd0);
        rst_n = 1'b0;
        mon_en = 1'b1;

        // Kyber PWM burst, fixed b
        for (int i = 0; i < 6; i++)
            issue_exp(1'b0, MAU_PWM, DW'(pwm_a[i]), DW'(2773), DW'(0), DW'(0), DW'(pwm_e[i]), DW'(0));
        idle(6);

        // Kyber directed add/sub/butterflies
        issue_exp(1'b0, MAU_ADD, DW'(3000), DW'(500), DW'(3328), DW'(1), DW'(171), DW'(0));
        issue_exp(1'b0, MAU_SUB, DW'(100), DW'(200), DW'(5), DW'(5), DW'(3229), DW'(0));
        issue_exp(1'b0, MAU_CT, DW'(10), DW'(2), DW'(3), DW'(0), DW'(16), DW'(4));
        issue_exp(1'b0, MAU_GS, DW'(10), DW'(2), DW'(3), DW'(0), DW'(12), DW'(24));

        // Dilithium boundary products and a reserved mode
        issue_exp(1'b1, MAU_PWM, DW'(8380416), DW'(8380416), DW'(0), DW'(0), DW'(1), DW'(0));
        issue_exp(1'b1, MAU_PWM, DW'(0), DW'(8380416), DW'(0), DW'(0), DW'(0), DW'(0));
        issue_exp(1'b0, 4'b1111, DW'(1234), DW'(2000), DW'(7), DW'(9), DW'(0), DW'(0));
        idle(6);

        // Enable pattern 1,0,1
        issue_exp(1'b0, MAU_ADD, DW'(1), DW'(2), DW'(3), DW'(4), DW'(3), DW'(7));
        idle(1);
        issue_exp(1'b0, MAU_SUB, DW'(0), DW'(1), DW'(3328), DW'(3328), DW'(3328), DW'(0));
        idle(6);

        // Reset during a burst: only the result that completes before reset emerges
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) rst_n = 1'b1;
            drive(1'b0, MAU_PWM, DW'(pwm_a[i]), DW'(2773), DW'(0), DW'(0));
            if (i == 0) exp_q.push_back({32'(cycle + 1), DW'(pwm_e[0]), DW'(0)});
        end
        @(negedge clk);
        poly_enable = 1'b0;
        check("midrst_valid", 64'(poly_valid), 64'd0);
        check("midrst_o0", 64'(poly_mau_o0), 64'd0);
        check("midrst_o1", 64'(poly_mau_o1), 64'd0);
        check("midrst_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b0;
        idle(8);
        issue_exp(1'b0, MAU_CT, DW'(10), DW'(2), DW'(3), DW'(0), DW'(16), DW'(4));
        idle(6);

        // 1000 random Dilithium products with occasional gaps
        for (int i = 0; i < 1000; i++) begin
            ra = DW'($urandom_range(0, DIL_Q - 1));
            rb = DW'($urandom_range(0, DIL_Q - 1));
            issue_model(1'b1, MAU_PWM, ra, rb, DW'($urandom_range(0, DIL_Q - 1)), DW'(0));
            if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
        end

        // Random modes and parameter sets switching every operation
        for (int i = 0; i < 300; i++) begin
            kd = 1'($urandom_range(0, 1));
            q = kd ? DW'(DIL_Q) : DW'(KYBER_Q);
            k = $urandom_range(0, 5);
            mode = (k == 5) ? 4'($urandom_range(5, 15)) : 4'(k);
            ra = DW'($urandom_range(0, int'(q) - 1));
            rb = DW'($urandom_range(0, int'(q) - 1));
            rc = DW'($urandom_range(0, int'(q) - 1));
            rd = DW'($urandom_range(0, int'(q) - 1));
            issue_model(kd, mode, ra, rb, rc, rd);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(1);

        // Drain with a cycle budget
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/poly_mau.md
# poly_mau

Pipelined modular arithmetic unit for the Kyber/Dilithium polynomial datapath. It takes operand pairs plus a twiddle or second pair each cycle. It computes modular add, subtract, pointwise multiply or an NTT butterfly, reducing products with Barrett reduction using the runtime modulus q, constant m and shift parameter N. It sits between the polynomial RAM read ports and the write-back path, one result pair per cycle.

## Interface
Parameters:
- DW, 24: operand and result width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset. Synchronous, active-high despite the name: clears every pipeline stage.
- poly_kd_sel  in  1  0 = Kyber, operands masked to bits [11:0]; 1 = Dilithium, full DW.
- poly_pwm2_odd_even_sel  in  1  reserved; ignored.
- poly_duv_mode  in  2  reserved; ignored.
- poly_alu_mode  in  4  operation select (see Operation).
- poly_compress  in  2  reserved, must be 00; ignored.
- poly_decompose  in  2  reserved, must be 00; ignored.
- poly_mau_a / _b / _c / _d  in  DW each  operands, all < q.
- poly_q  in  DW  modulus (3329 or 8380417).
- poly_barret_m  in  25  floor(2^(2N)/q): 5039 for Kyber, 8396807 for Dilithium.
- poly_mm_N  in  5  N, with q < 2^N: 12 for Kyber, 23 for Dilithium.
- poly_enable  in  1  the operands on this cycle are valid.
- poly_valid  out  1  o0/o1 carry a result.
- poly_mau_o0, poly_mau_o1  out  DW  results, always in [0, q).

## Operation
Mode encodings:
- 0000 ADD: o0=(a+b) mod q; o1=(c+d) mod q.
- 0001 SUB: o0=(a−b) mod q; o1=(c−d) mod q.
- 0010 CT butterfly: t=b·c mod q; o0=(a+t) mod q; o1=(a−t) mod q.
- 0011 GS butterfly: o0=(a+b) mod q; o1=((a−b) mod q)·c mod q.
- 0100 PWM: o0=a·b mod q; o1=0.
- Any other code: o0=o1=0; poly_valid still asserted.

Arithmetic rules:
- Add: sum of two values < q; subtract q if the sum ≥ q.
- Subtract: add q if the difference is negative.
- Barrett reduction of product p < q² (2N bits):
  - t = (p·m) >> 2N;
  - r = p − t·q;
  - apply up to two conditional subtractions of q, so r < q.
- Internal widths: product ≤ 48 bits; p·m ≤ 73 bits. No truncation before the shift.
- A single multiplier plus one Barrett reducer serves every mode.
- Mode, q, m and N are sampled with the operands and travel down the pipeline. Changing them mid-stream affects only newly accepted operands.

## Timing
- Fixed latency of 4 cycles for every mode.
- Operands sampled at edge k with poly_enable=1 appear on o0/o1 with poly_valid=1 after edge k+4.
- Pipeline stages:
  - S1: register operands and mode.
  - S2: pre-add/sub and multiply.
  - S3: Barrett quotient estimate and p − t·q.
  - S4: final correction, add/sub for butterflies, output register.
- Throughput: one operation per cycle, no stalls, no backpressure.
- poly_valid is poly_enable delayed by 4 cycles.
- While poly_valid=0, o0=o1=0.
- Reset values: poly_valid=0, o0=0, o1=0, all stage valid bits 0.
- Reset asserted mid-stream: in-flight results are discarded. Outputs read 0/invalid from the edge where reset is sampled. The first operands accepted after reset release appear 4 cycles later.
- Back-to-back enables produce back-to-back valid results in input order. A gap in poly_enable gives an equal gap in poly_valid.

## Structure
- Shared package holds:
  - mode encodings: MAU_ADD, MAU_SUB, MAU_CT, MAU_GS, MAU_PWM;
  - compress/decompose encodings;
  - Kyber and Dilithium constants: q, m, N.
- One natural sub-module, poly_mau_barrett: pipelined Barrett reducer with inputs (p, q, m, N) and output r < q, 2 register stages.
- Mode muxing and the add/sub logic stay in the top level.

## Test plan
- PWM, Kyber (q=3329, m=5039, N=12), b=2773 fixed; a = 245, 1603, 497, 940, 2815, 2961 on consecutive cycles.
  - Required: o0 = 269, 904, 3304, 13, 2819, 1539 on 6 consecutive cycles, 4 cycles after each input; o1=0.
  - poly_valid high for exactly 6 cycles.
- ADD/SUB, Kyber:
  - ADD a=3000, b=500, c=3328, d=1 → o0=171, o1=0.
  - SUB a=100, b=200, c=5, d=5 → o0=3229, o1=0.
- CT, Kyber, a=10, b=2, c=3 → o0=16, o1=4. GS, same operands → o0=12, o1=24.
- PWM, Dilithium (q=8380417, m=8396807, N=23), a=b=8380416 → o0=1.
  - Also check a=0 → 0.
  - Also run 1000 random pairs against a reference model.
- Reset and gaps:
  - Assert rst_n during a 6-operand burst → outputs 0 and valid low on the next edge. Nothing from the burst emerges after release.
  - Enable pattern 1,0,1 → valid pattern 1,0,1 shifted by 4 cycles.
- Reserved mode 1111 with enable → valid=1, o0=o1=0.
